// File: rtl/range_pkg.sv
`default_nettype none
// ============================================================================
// Module      : range_pkg
// Description : Shared types for the multichannel range tracker.
//               err_t      - protocol error codes reported on err_code
//               ch_state_t - per-channel sequence state
// Revision    : 1.0 - initial release
// ============================================================================
package range_pkg;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_FINISH_IDLE = 3'd1,
        ERR_GO_FINISH   = 3'd2,
        ERR_RESTART     = 3'd3,
        ERR_BAD_CH      = 3'd4
    } err_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/range_channel.sv
`default_nettype none
// ============================================================================
// Module      : range_channel
// Description : One tracker channel: IDLE/RUN state, running min/max and a
//               saturating sample counter. Presents the values the channel
//               will hold after this cycle so the top can register a result
//               that already includes the finish sample.
// Ports       : clock, reset_n     - clock / async active-low reset
//               i_sel              - sample is valid and addressed here
//               i_go, i_finish     - sequence markers
//               i_data             - sample value
//               o_res_valid        - a result record is due this cycle
//               o_res_min/max      - updated min/max (result fields)
//               o_res_count        - updated sample count
//               o_err_code         - protocol error raised this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module range_channel
    import range_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_sel,
    input  logic             i_go,
    input  logic             i_finish,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_res_valid,
    output logic [WIDTH-1:0] o_res_min,
    output logic [WIDTH-1:0] o_res_max,
    output logic [CNT_W-1:0] o_res_count,
    output err_t             o_err_code
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    ch_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_min, r_max, w_min_nxt, w_max_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt, w_count_inc;
    logic             w_lt_min, w_gt_max;

    // Strict compares: equal samples never replace the stored extreme.
    if (SIGNED) begin : g_signed
        assign w_lt_min = $signed(i_data) < $signed(r_min);
        assign w_gt_max = $signed(i_data) > $signed(r_max);
    end else begin : g_unsigned
        assign w_lt_min = i_data < r_min;
        assign w_gt_max = i_data > r_max;
    end

    assign w_count_inc = (r_count == c_cnt_max) ? r_count : r_count + c_cnt_one;

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_max_nxt   = r_max;
        w_count_nxt = r_count;
        o_res_valid = 1'b0;
        o_err_code  = ERR_NONE;
        if (i_sel) begin
            if (i_go && i_finish) begin
                // Ambiguous marker pair: drop the sample, keep the sequence.
                o_err_code = ERR_GO_FINISH;
            end else if (i_go) begin
                if (r_state == RUN) begin
                    o_err_code = ERR_RESTART;
                end
                w_min_nxt   = i_data;
                w_max_nxt   = i_data;
                w_count_nxt = c_cnt_one;
                w_state_nxt = RUN;
            end else if (r_state == RUN) begin
                if (w_lt_min) begin
                    w_min_nxt = i_data;
                end
                if (w_gt_max) begin
                    w_max_nxt = i_data;
                end
                w_count_nxt = w_count_inc;
                if (i_finish) begin
                    o_res_valid = 1'b1;
                    w_state_nxt = IDLE;
                end
            end else if (i_finish) begin
                o_err_code = ERR_FINISH_IDLE;
            end
        end
    end

    assign o_res_min   = w_min_nxt;
    assign o_res_max   = w_max_nxt;
    assign o_res_count = w_count_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_min   <= '0;
            r_max   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_max   <= w_max_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multichannel_range_tracker.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_range_tracker
// Description : Running min/max/range/count over NUM_CH interleaved sample
//               streams delimited by go/finish markers. One registered result
//               record per finished sequence; protocol errors are reported
//               per channel with a sticky status vector.
// Ports       : clock, reset_n             - clock / async active-low reset
//               in_valid, in_ch, data_in   - tagged sample
//               go, finish                 - sequence markers
//               clear_err                  - clears err_status
//               out_valid, out_ch, out_min, out_max, out_range, out_count
//                                          - result record (valid pulses)
//               err_valid, err_ch, err_code - error report (valid pulses)
//               err_status                 - sticky per-channel error flags
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_range_tracker
    import range_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 8,
    parameter bit  SIGNED = 1'b0,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              go,
    input  logic              finish,
    input  logic              clear_err,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [WIDTH-1:0]  out_min,
    output logic [WIDTH-1:0]  out_max,
    output logic [WIDTH-1:0]  out_range,
    output logic [CNT_W-1:0]  out_count,
    output logic              err_valid,
    output logic [CH_W-1:0]   err_ch,
    output logic [2:0]        err_code,
    output logic [NUM_CH-1:0] err_status
);

    // One extra bit so the range check is meaningful for every NUM_CH.
    localparam logic [CH_W:0] c_num_ch = (CH_W + 1)'(NUM_CH);

    logic              w_bad_ch;
    logic [NUM_CH-1:0] w_sel, w_res_valid, w_err_set;
    logic [WIDTH-1:0]  w_res_min [NUM_CH];
    logic [WIDTH-1:0]  w_res_max [NUM_CH];
    logic [CNT_W-1:0]  w_res_count [NUM_CH];
    err_t              w_ch_err [NUM_CH];

    logic              w_any_res;
    logic [WIDTH-1:0]  w_min, w_max;
    logic [CNT_W-1:0]  w_count;
    err_t              w_err;

    logic              r_out_valid, r_err_valid;
    logic [CH_W-1:0]   r_out_ch, r_err_ch;
    logic [WIDTH-1:0]  r_out_min, r_out_max, r_out_range;
    logic [CNT_W-1:0]  r_out_count;
    err_t              r_err_code;
    logic [NUM_CH-1:0] r_err_status;

    assign w_bad_ch = ({1'b0, in_ch} >= c_num_ch);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_sel[g] = in_valid && !w_bad_ch && (in_ch == CH_W'(g));

        range_channel #(
            .WIDTH  (WIDTH),
            .CNT_W  (CNT_W),
            .SIGNED (SIGNED)
        ) u_channel (
            .clock       (clock),
            .reset_n     (reset_n),
            .i_sel       (w_sel[g]),
            .i_go        (go),
            .i_finish    (finish),
            .i_data      (data_in),
            .o_res_valid (w_res_valid[g]),
            .o_res_min   (w_res_min[g]),
            .o_res_max   (w_res_max[g]),
            .o_res_count (w_res_count[g]),
            .o_err_code  (w_ch_err[g])
        );
    end

    // At most one channel is selected per cycle, so a priority-free
    // scan is enough; the reporting channel is always in_ch.
    always_comb begin
        w_any_res = 1'b0;
        w_min     = '0;
        w_max     = '0;
        w_count   = '0;
        w_err     = (in_valid && w_bad_ch) ? ERR_BAD_CH : ERR_NONE;
        w_err_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_res_valid[i]) begin
                w_any_res = 1'b1;
                w_min     = w_res_min[i];
                w_max     = w_res_max[i];
                w_count   = w_res_count[i];
            end
            if (w_ch_err[i] != ERR_NONE) begin
                w_err        = w_ch_err[i];
                w_err_set[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_min    <= '0;
            r_out_max    <= '0;
            r_out_range  <= '0;
            r_out_count  <= '0;
            r_err_valid  <= 1'b0;
            r_err_ch     <= '0;
            r_err_code   <= ERR_NONE;
            r_err_status <= '0;
        end else begin
            r_out_valid <= w_any_res;
            if (w_any_res) begin
                r_out_ch    <= in_ch;
                r_out_min   <= w_min;
                r_out_max   <= w_max;
                r_out_range <= w_max - w_min;
                r_out_count <= w_count;
            end
            r_err_valid <= (w_err != ERR_NONE);
            if (w_err != ERR_NONE) begin
                r_err_ch   <= in_ch;
                r_err_code <= w_err;
            end
            // A new error on the clearing cycle survives the clear.
            r_err_status <= (clear_err ? '0 : r_err_status) | w_err_set;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_min    = r_out_min;
    assign out_max    = r_out_max;
    assign out_range  = r_out_range;
    assign out_count  = r_out_count;
    assign err_valid  = r_err_valid;
    assign err_ch     = r_err_ch;
    assign err_code   = r_err_code;
    assign err_status = r_err_status;

endmodule
`default_nettype wire

// File: tb/tb_multichannel_range_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_multichannel_range_tracker
// Description : Scoreboard bench. DUT A uses default parameters; DUT B is
//               8-bit signed, 3 channels, 2-bit counter (covers signed
//               compare, count saturation and out-of-range channel tags).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multichannel_range_tracker;
    import range_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int ch; int mn; int mx; int rg; int cnt; int cyc; } res_t;
    typedef struct { int ch; int code; int cyc; } err_rec_t;

    res_t     qa[$], qb[$];
    err_rec_t qea[$], qeb[$];
    res_t     ea, eb;
    err_rec_t eea, eeb;

    // DUT A signals
    logic        a_in_valid, a_go, a_finish, a_clear;
    logic [1:0]  a_in_ch;
    logic [15:0] a_data;
    logic        a_out_valid, a_err_valid;
    logic [1:0]  a_out_ch, a_err_ch;
    logic [15:0] a_out_min, a_out_max, a_out_range;
    logic [7:0]  a_out_count;
    logic [2:0]  a_err_code;
    logic [3:0]  a_err_status;

    // DUT B signals
    logic        b_in_valid, b_go, b_finish, b_clear;
    logic [1:0]  b_in_ch;
    logic [7:0]  b_data;
    logic        b_out_valid, b_err_valid;
    logic [1:0]  b_out_ch, b_err_ch;
    logic [7:0]  b_out_min, b_out_max, b_out_range;
    logic [1:0]  b_out_count;
    logic [2:0]  b_err_code;
    logic [2:0]  b_err_status;

    multichannel_range_tracker u_dut_a (
        .clock(clock), .reset_n(reset_n), .in_valid(a_in_valid), .in_ch(a_in_ch),
        .data_in(a_data), .go(a_go), .finish(a_finish), .clear_err(a_clear),
        .out_valid(a_out_valid), .out_ch(a_out_ch), .out_min(a_out_min),
        .out_max(a_out_max), .out_range(a_out_range), .out_count(a_out_count),
        .err_valid(a_err_valid), .err_ch(a_err_ch), .err_code(a_err_code),
        .err_status(a_err_status)
    );

    multichannel_range_tracker #(
        .WIDTH(8), .NUM_CH(3), .CNT_W(2), .SIGNED(1'b1)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .in_ch(b_in_ch),
        .data_in(b_data), .go(b_go), .finish(b_finish), .clear_err(b_clear),
        .out_valid(b_out_valid), .out_ch(b_out_ch), .out_min(b_out_min),
        .out_max(b_out_max), .out_range(b_out_range), .out_count(b_out_count),
        .err_valid(b_err_valid), .err_ch(b_err_ch), .err_code(b_err_code),
        .err_status(b_err_status)
    );

    // ---------------- scoreboard monitors ----------------
    always @(negedge clock) begin
        if (a_out_valid === 1'b1) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_result: got unexpected ch=%0d min=%0d max=%0d at cyc=%0d, required none",
                         a_out_ch, a_out_min, a_out_max, cyc);
            end else begin
                ea = qa.pop_front();
                if (int'(a_out_ch) !== ea.ch || int'(a_out_min) !== ea.mn || int'(a_out_max) !== ea.mx ||
                    int'(a_out_range) !== ea.rg || int'(a_out_count) !== ea.cnt || cyc !== ea.cyc) begin
                    bad++;
                    $display("FAIL a_result: got ch=%0d min=%0d max=%0d rng=%0d cnt=%0d cyc=%0d, required ch=%0d min=%0d max=%0d rng=%0d cnt=%0d cyc=%0d",
                             a_out_ch, a_out_min, a_out_max, a_out_range, a_out_count, cyc,
                             ea.ch, ea.mn, ea.mx, ea.rg, ea.cnt, ea.cyc);
                end
            end
        end
        if (a_err_valid === 1'b1) begin
            total++;
            if (qea.size() == 0) begin
                bad++;
                $display("FAIL a_error: got unexpected ch=%0d code=%0d at cyc=%0d, required none",
                         a_err_ch, a_err_code, cyc);
            end else begin
                eea = qea.pop_front();
                if (int'(a_err_ch) !== eea.ch || int'(a_err_code) !== eea.code || cyc !== eea.cyc) begin
                    bad++;
                    $display("FAIL a_error: got ch=%0d code=%0d cyc=%0d, required ch=%0d code=%0d cyc=%0d",
                             a_err_ch, a_err_code, cyc, eea.ch, eea.code, eea.cyc);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (b_out_valid === 1'b1) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_result: got unexpected ch=%0d min=%0d max=%0d at cyc=%0d, required none",
                         b_out_ch, b_out_min, b_out_max, cyc);
            end else begin
                eb = qb.pop_front();
                if (int'(b_out_ch) !== eb.ch || int'(b_out_min) !== eb.mn || int'(b_out_max) !== eb.mx ||
                    int'(b_out_range) !== eb.rg || int'(b_out_count) !== eb.cnt || cyc !== eb.cyc) begin
                    bad++;
                    $display("FAIL b_result: got ch=%0d min=%0d max=%0d rng=%0d cnt=%0d cyc=%0d, required ch=%0d min=%0d max=%0d rng=%0d cnt=%0d cyc=%0d",
                             b_out_ch, b_out_min, b_out_max, b_out_range, b_out_count, cyc,
                             eb.ch, eb.mn, eb.mx, eb.rg, eb.cnt, eb.cyc);
                end
            end
        end
        if (b_err_valid === 1'b1) begin
            total++;
            if (qeb.size() == 0) begin
                bad++;
                $display("FAIL b_error: got unexpected ch=%0d code=%0d at cyc=%0d, required none",
                         b_err_ch, b_err_code, cyc);
            end else begin
                eeb = qeb.pop_front();
                if (int'(b_err_ch) !== eeb.ch || int'(b_err_code) !== eeb.code || cyc !== eeb.cyc) begin
                    bad++;
                    $display("FAIL b_error: got ch=%0d code=%0d cyc=%0d, required ch=%0d code=%0d cyc=%0d",
                             b_err_ch, b_err_code, cyc, eeb.ch, eeb.code, eeb.cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge; the sample is taken on the next rising edge.
    task automatic drv_a(input int ch, input int d, input bit g, input bit f);
        b_in_valid = 1'b0; b_go = 1'b0; b_finish = 1'b0;
        a_in_valid = 1'b1; a_in_ch = 2'(ch); a_data = 16'(d); a_go = g; a_finish = f;
        @(negedge clock);
    endtask

    task automatic drv_b(input int ch, input int d, input bit g, input bit f);
        a_in_valid = 1'b0; a_go = 1'b0; a_finish = 1'b0;
        b_in_valid = 1'b1; b_in_ch = 2'(ch); b_data = 8'(d); b_go = g; b_finish = f;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        a_in_valid = 1'b0; a_go = 1'b0; a_finish = 1'b0;
        b_in_valid = 1'b0; b_go = 1'b0; b_finish = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic exp_a(input int ch, input int mn, input int mx, input int rg, input int cnt);
        qa.push_back('{ch, mn, mx, rg, cnt, cyc + 1});
    endtask

    task automatic exp_b(input int ch, input int mn, input int mx, input int rg, input int cnt);
        qb.push_back('{ch, mn, mx, rg, cnt, cyc + 1});
    endtask

    task automatic exp_err_a(input int ch, input err_t code);
        qea.push_back('{ch, int'(code), cyc + 1});
    endtask

    task automatic exp_err_b(input int ch, input err_t code);
        qeb.push_back('{ch, int'(code), cyc + 1});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({a_out_valid, a_out_ch, a_out_min, a_out_max, a_out_range, a_out_count} !== '0) begin
            bad++;
            $display("FAIL reset_a_out: got v=%b min=%0d max=%0d cnt=%0d, required all 0",
                     a_out_valid, a_out_min, a_out_max, a_out_count);
        end
        total++;
        if ({a_err_valid, a_err_ch, a_err_code, a_err_status} !== '0) begin
            bad++;
            $display("FAIL reset_a_err: got v=%b code=%0d status=%b, required all 0",
                     a_err_valid, a_err_code, a_err_status);
        end
        total++;
        if ({b_out_valid, b_out_min, b_out_max, b_out_count, b_err_valid, b_err_status} !== '0) begin
            bad++;
            $display("FAIL reset_b: got v=%b min=%0d max=%0d status=%b, required all 0",
                     b_out_valid, b_out_min, b_out_max, b_err_status);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic;
        drv_a(0, 5, 1, 0);
        drv_a(0, 9, 0, 0);
        drv_a(0, 2, 0, 0);
        exp_a(0, 2, 9, 7, 4);
        drv_a(0, 7, 0, 1);
        idle(3);
        total++;
        if (a_out_valid !== 1'b0 || a_out_min !== 16'd2 || a_out_max !== 16'd9) begin
            bad++;
            $display("FAIL hold: got v=%b min=%0d max=%0d, required v=0 min=2 max=9",
                     a_out_valid, a_out_min, a_out_max);
        end
    endtask

    task automatic test_interleave;
        drv_a(1, 100, 1, 0);
        drv_a(2, 3, 1, 0);
        exp_a(1, 40, 100, 60, 2);
        drv_a(1, 40, 0, 1);
        exp_a(2, 3, 3, 0, 2);
        drv_a(2, 3, 0, 1);
        drv_a(3, 77, 0, 0);   // sample on an idle channel is ignored
        idle(2);
    endtask

    task automatic test_finish_idle;
        exp_err_a(3, ERR_FINISH_IDLE);
        drv_a(3, 11, 0, 1);
        idle(1);
        total++;
        if (a_err_status !== 4'b1000) begin
            bad++;
            $display("FAIL status_set: got %b, required 1000", a_err_status);
        end
        a_clear = 1'b1;
        @(negedge clock);
        a_clear = 1'b0;
        total++;
        if (a_err_status !== 4'b0000) begin
            bad++;
            $display("FAIL status_clear: got %b, required 0000", a_err_status);
        end
        exp_err_a(2, ERR_FINISH_IDLE);
        a_clear = 1'b1;
        drv_a(2, 0, 0, 1);
        a_clear = 1'b0;
        idle(1);
        total++;
        if (a_err_status !== 4'b0100) begin
            bad++;
            $display("FAIL status_set_wins: got %b, required 0100", a_err_status);
        end
    endtask

    task automatic test_go_finish;
        drv_a(0, 50, 1, 0);
        drv_a(0, 60, 0, 0);
        exp_err_a(0, ERR_GO_FINISH);
        drv_a(0, 1000, 1, 1);
        exp_a(0, 50, 60, 10, 3);
        drv_a(0, 55, 0, 1);
        idle(1);
        total++;
        if (a_err_status !== 4'b0101) begin
            bad++;
            $display("FAIL status_go_finish: got %b, required 0101", a_err_status);
        end
    endtask

    task automatic test_restart;
        drv_a(1, 10, 1, 0);
        drv_a(1, 20, 0, 0);
        exp_err_a(1, ERR_RESTART);
        drv_a(1, 7, 1, 0);
        exp_a(1, 7, 8, 1, 2);
        drv_a(1, 8, 0, 1);
        idle(1);
        total++;
        if (a_err_status !== 4'b0111) begin
            bad++;
            $display("FAIL status_restart: got %b, required 0111", a_err_status);
        end
    endtask

    task automatic test_back_to_back;
        drv_a(0, 1, 1, 0);
        exp_a(0, 1, 2, 1, 2);
        drv_a(0, 2, 0, 1);
        drv_a(0, 30, 1, 0);
        exp_a(0, 30, 30, 0, 2);
        drv_a(0, 30, 0, 1);
        drv_a(3, 65535, 1, 0);
        drv_a(3, 0, 0, 0);
        exp_a(3, 0, 65535, 65535, 3);
        drv_a(3, 100, 0, 1);
        idle(2);
    endtask

    task automatic test_signed;
        drv_b(0, -128, 1, 0);
        exp_b(0, 128, 127, 255, 2);
        drv_b(0, 127, 0, 1);
        drv_b(1, -5, 1, 0);
        drv_b(1, 3, 0, 0);
        exp_b(1, 251, 3, 8, 3);
        drv_b(1, -2, 0, 1);
        exp_err_b(3, ERR_BAD_CH);
        drv_b(3, 0, 1, 0);
        idle(1);
        total++;
        if (b_err_status !== 3'b000) begin
            bad++;
            $display("FAIL bad_ch_status: got %b, required 000", b_err_status);
        end
    endtask

    task automatic test_saturate;
        drv_b(1, 1, 1, 0);
        for (int i = 2; i <= 5; i++) drv_b(1, i, 0, 0);
        exp_b(1, 1, 6, 5, 3);
        drv_b(1, 6, 0, 1);
        idle(2);
    endtask

    task automatic test_reset_mid;
        drv_b(2, 10, 1, 0);
        drv_b(2, 20, 0, 0);
        drv_a(0, 5, 1, 0);
        idle(0);
        reset_n = 1'b0;
        @(negedge clock);
        total++;
        if (a_err_status !== 4'b0000 || a_out_min !== 16'd0 || b_out_max !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: got a_status=%b a_min=%0d b_max=%0d, required 0 0 0",
                     a_err_status, a_out_min, b_out_max);
        end
        reset_n = 1'b1;
        @(negedge clock);
        exp_err_b(2, ERR_FINISH_IDLE);
        drv_b(2, 30, 0, 1);
        exp_err_a(0, ERR_FINISH_IDLE);
        drv_a(0, 6, 0, 1);
        idle(2);
    endtask

    task automatic test_drain;
        total++;
        if (qa.size() + qb.size() + qea.size() + qeb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d/%0d/%0d outstanding records, required 0",
                     qa.size(), qb.size(), qea.size(), qeb.size());
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        a_in_valid = 1'b0; a_go = 1'b0; a_finish = 1'b0; a_clear = 1'b0;
        a_in_ch    = '0;   a_data = '0;
        b_in_valid = 1'b0; b_go = 1'b0; b_finish = 1'b0; b_clear = 1'b0;
        b_in_ch    = '0;   b_data = '0;
        test_reset;
        test_basic;
        test_interleave;
        test_finish_idle;
        test_go_finish;
        test_restart;
        test_back_to_back;
        test_signed;
        test_saturate;
        test_reset_mid;
        test_drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
